// File: rtl/uart_bus_master.sv
// ============================================================================
// Module   : uart_bus_master
// Function : valid/ready request channel to timed UART register accesses
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_bus_master #(
  parameter int SETUP_CYCLES    = 1,
  parameter int ACCESS_CYCLES   = 3,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_write_i,
  input  logic [2:0] req_address_i,
  input  logic [7:0] req_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic       chip_sel_n_o,
  output logic [2:0] address_o,
  output logic       read_write_o,
  inout  wire  [7:0] data_io,
  input  logic       ireq_n_i,
  output logic       irq_o,
  output logic       busy_o
);

  localparam int c_max_cyc =
    (SETUP_CYCLES > ACCESS_CYCLES)
      ? ((SETUP_CYCLES  > RECOVERY_CYCLES) ? SETUP_CYCLES  : RECOVERY_CYCLES)
      : ((ACCESS_CYCLES > RECOVERY_CYCLES) ? ACCESS_CYCLES : RECOVERY_CYCLES);
  localparam int c_cnt_w = $clog2(c_max_cyc) + 1;

  localparam logic [c_cnt_w-1:0] c_setup_load  = c_cnt_w'(SETUP_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_access_load = c_cnt_w'(ACCESS_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_recov_load  = c_cnt_w'(RECOVERY_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one     = c_cnt_w'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    RECOVER = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic [2:0]           addr_q, addr_d;
  logic                 rw_q, rw_d;
  logic [7:0]           wdata_q, wdata_d;
  logic                 oe_q, oe_d;
  logic                 cs_n_q, cs_n_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 irq_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d = SETUP;
          cnt_d   = c_setup_load;
          addr_d  = req_address_i;
          rw_d    = !req_write_i;
          wdata_d = req_wdata_i;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = ACCESS;
          cnt_d   = c_access_load;
        end else begin
          cnt_d = cnt_q - c_cnt_one;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d     = RECOVER;
          cnt_d       = c_recov_load;
          rsp_valid_d = 1'b1;
          // Read data is captured on the edge that closes the strobe window.
          if (rw_q) begin
            rdata_d = data_io;
          end
        end else begin
          cnt_d = cnt_q - c_cnt_one;
        end
      end
      RECOVER: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - c_cnt_one;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Bus controls are registered from the next state so they never glitch.
    cs_n_d = (state_d != ACCESS);
    oe_d   = !rw_d && ((state_d == SETUP) || (state_d == ACCESS));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= 3'd0;
      rw_q        <= 1'b1;
      wdata_q     <= 8'd0;
      oe_q        <= 1'b0;
      cs_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'd0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      oe_q        <= oe_d;
      cs_n_q      <= cs_n_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      irq_q       <= !ireq_n_i;
    end
  end

  assign data_io      = oe_q ? wdata_q : 8'hzz;
  assign req_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rdata_q;
  assign chip_sel_n_o = cs_n_q;
  assign address_o    = addr_q;
  assign read_write_o = rw_q;
  assign irq_o        = irq_q;

endmodule

`default_nettype wire
